i2s_receive: RTL

I2S receiver: deserialises the `sd` line of an I2S ADC/codec bus into 32-bit channel words and presents them as an AXI4-Stream master. `sck` and `ws` come from `i2s_controller`; the block is clocked by `mclk`. It is the capture-side counterpart of `i2s_transmit` and shares the same bus timing: MSB one `sck` after the `ws` edge, `ws=0` left, `ws=1` right.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_rx_fifo.sv | 54 +++++
 rtl/i2s_receive.sv | 132 +++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S capture path.
// Channel encoding follows ws: low selects left, high selects right.
package i2s_pkg;

  localparam int unsigned I2S_DATA_WIDTH = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Two-entry FIFO between the I2S deserialiser and the AXI4-Stream output.
// A push while full is accepted only if a pop happens in the same cycle.
module i2s_rx_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // When full, the write slot is the one being popped this cycle.
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_receive.sv
// I2S receiver: synchronises sck/ws/sd into mclk, deserialises MSB-first channel
// words and presents them on an AXI4-Stream master through a 2-entry FIFO.
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
  localparam logic [CntW-1:0] CntMax  = CntW'(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  logic                  r_sck_meta, r_sck_s, r_sck_q;
  logic                  r_ws_meta, r_ws_s;
  logic                  r_sd_meta, r_sd_s;
  logic                  r_ws_last;
  logic [DATA_WIDTH-2:0] r_shreg;
  logic [CntW-1:0]       r_bitcnt;
  logic                  r_overflow;
  rx_state_e             r_state;
  rx_state_e             w_state_next;

  logic                  w_rise;
  logic                  w_boundary;
  logic                  w_cnt_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH:0]   w_fifo_out;

  assign w_rise     = r_sck_s & ~r_sck_q;
  assign w_boundary = w_rise & (r_ws_s != r_ws_last);
  assign w_cnt_full = (r_bitcnt == CntLast);
  // The bit arriving on the boundary edge is the LSB of the finishing word.
  assign w_word     = {r_shreg, r_sd_s};

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_sck_meta <= 1'b0;
      r_sck_s    <= 1'b0;
      r_sck_q    <= 1'b0;
      r_ws_meta  <= 1'b0;
      r_ws_s     <= 1'b0;
      r_sd_meta  <= 1'b0;
      r_sd_s     <= 1'b0;
      r_ws_last  <= CH_LEFT;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sck_meta <= sck;
      r_sck_s    <= r_sck_meta;
      r_sck_q    <= r_sck_s;
      r_ws_meta  <= ws;
      r_ws_s     <= r_ws_meta;
      r_sd_meta  <= sd;
      r_sd_s     <= r_sd_meta;
      if (w_rise) begin
        r_shreg   <= w_word[DATA_WIDTH-2:0];
        r_ws_last <= r_ws_s;
        if (w_boundary) begin
          r_bitcnt <= '0;
        end else if (r_bitcnt != CntMax) begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_boundary) begin
      case (r_state)
        S_SYNC:  w_state_next = S_RECV;
        S_RECV:  w_state_next = w_cnt_full ? S_RECV : S_SYNC;
        default: w_state_next = S_SYNC;
      endcase
    end
  end

  always_comb begin
    w_push = 1'b0;
    if (r_state == S_RECV && w_boundary && w_cnt_full) begin
      w_push = 1'b1;
    end
  end

  assign w_pop = ~w_empty & M_AXIS_TREADY;

  i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (M_AXIS_ACLK),
    .i_rst_n (M_AXIS_ARESETN),
    .i_push  (w_push),
    .i_data  ({(r_ws_last == CH_RIGHT), w_word}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign M_AXIS_TVALID = ~w_empty;
  assign M_AXIS_TDATA  = w_fifo_out[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = w_fifo_out[DATA_WIDTH];
  assign overflow      = r_overflow;

endmodule
